mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single-port 64x64 lane memory (`system_mem`) in the low-area Keccak datapath.
- Requesters:
  - Host: loads/unloads state lanes.
  - Core: the round engine that reads and writes lanes during the permutation.
- Issues at most one memory op per cycle, using round-robin with an optional core lock. Returns registered read data to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 6, lane address width.
- DATA_WIDTH, 64, lane width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- h_req  in  1  host request valid
- h_we  in  1  host op: 1=write, 0=read
- h_addr  in  ADDR_WIDTH  host lane address
- h_wdata  in  DATA_WIDTH  host write data
- h_gnt  out  1  host op accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_WIDTH  host read data
- c_req, c_we, c_addr, c_wdata, c_gnt, c_rvalid, c_rdata: core equivalents, same widths and meanings
- c_lock  in  1  core requests exclusive access
- mem_enR  out  1  memory read enable
- mem_enW  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory registered read output

Behaviour:
- Grant is combinational, in the same cycle as the request. Op is accepted iff req && gnt. Requester holds req/we/addr/wdata stable until granted.
- At most one of h_gnt/c_gnt high per cycle. Zero gnt when no req.
- Round-robin:
  - Register last_core (reset 0).
  - Both requesting: grant core if last_core==0, else host.
  - Single requester: granted unless blocked by lock.
  - last_core <= granted-is-core on every grant.
- Lock:
  - Register lock_act (reset 0).
  - Set on a core grant with c_lock=1.
  - Cleared in any cycle c_lock=0 is sampled.
  - While lock_act=1, h_gnt=0 and core is granted whenever c_req=1.
  - Lock asserted while host is being granted: host op completes; lock takes effect after the next core grant.
- Memory command, combinational from the grant:
  - mem_enW = gnt && we
  - mem_enR = gnt && !we
  - mem_addr/mem_wdata are muxed from the granted requester.
  - All mem outputs are 0 when idle.
- Read return:
  - Registers rd_pend (reset 0) and rd_core (reset 0) capture a granted read.
  - Next cycle: rvalid=1 for one cycle to the owner (h_rvalid = rd_pend && !rd_core; c_rvalid = rd_pend && rd_core).
  - Read latency is exactly 1 cycle after grant.
  - h_rdata/c_rdata are both driven from mem_rdata; only meaningful with rvalid.
- Back-to-back reads every cycle are supported: rd_pend is re-loaded every cycle.
- Write then read of the same address in consecutive cycles returns the new data.
- Reset (any time, including mid-operation): pending rvalid is dropped, lock is released, last_core=0. All outputs read 0 while rst=1.

Optional Feature:
- Macro MEM_ARB_STALL_CNT_EN.
- Defined:
  - Adds output h_stall_cnt [15:0] (reset 0). Increments each cycle h_req && !h_gnt, saturating at 16'hFFFF.
  - Adds input stall_clr, which clears the counter synchronously (clear wins over increment).
- Undefined: no port, no logic; arbitration is identical.

Decomposition:
- Shared package keccak_mem_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH constants.
  - LANE_COUNT=25.
  - Op encoding constants OP_RD=0, OP_WR=1.
- Round-robin pick plus lock logic is a natural sub-module, rr_lock_arb2: inputs h_req, c_req, c_lock; outputs gnt vector, lock_act.
- Datapath muxing and read-tag tracking stay in mem_arbiter.

Test Plan:
- Host-only access:
  - Host writes addr 5 = 64'hDEAD_BEEF_0123_4567.
  - Next cycle host reads addr 5 -> h_gnt=1 both cycles; h_rvalid=1 one cycle after the read grant with h_rdata=64'hDEAD_BEEF_0123_4567; c_rvalid stays 0.
- Contention:
  - Both request reads every cycle from reset, host addr 1, core addr 2 -> grants alternate core, host, core, host.
  - Each rvalid follows its own grant by 1 cycle with the correct lane data.
- Lock:
  - Core granted with c_lock=1; host requests for 10 cycles while core keeps c_req=1 -> h_gnt=0 throughout.
  - Drop c_lock -> host granted next contended cycle.
- Simultaneous edge: host granted in the same cycle c_lock rises -> host op completes; lock becomes active after the following core grant.
- Reset mid-read:
  - Assert rst in the cycle after a core read grant -> c_rvalid=0, all mem outputs 0.
  - After release, first contended grant goes to core.
- With MEM_ARB_STALL_CNT_EN: host stalled 7 cycles -> h_stall_cnt=7; stall_clr pulsed during a stall -> counter reads 0 the next cycle.

Source files
------------

// File: rtl/keccak_mem_pkg.sv
// Shared constants and types for the Keccak lane-memory datapath.
//   ADDR_WIDTH / DATA_WIDTH : lane address and lane data widths
//   LANE_COUNT              : number of live lanes in the 5x5 state
//   OP_RD / OP_WR           : encoding of the requester "we" bit
//   GNT_HOST / GNT_CORE     : bit positions inside a two-bit grant vector
//   rd_tag_t                : read-return tag (pending flag + owner)
package keccak_mem_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 64;
    localparam int LANE_COUNT = 25;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int GNT_HOST = 0;
    localparam int GNT_CORE = 1;

    typedef struct packed {
        logic pend;   // a read was granted last cycle
        logic core;   // 1: owner is the core, 0: owner is the host
    } rd_tag_t;

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-requester round-robin picker with a core lock.
//   clk, rst   : clock, asynchronous active-high reset
//   h_req      : host request (already qualified by the caller)
//   c_req      : core request (already qualified by the caller)
//   c_lock     : core asks for exclusive access
//   gnt[1:0]   : one-hot-or-zero grant, indexed by GNT_HOST / GNT_CORE
//   lock_act   : lock currently in force (host is blocked)
// The lock only engages on a core grant that carries c_lock, so a host op
// already being granted when c_lock rises still completes.
module rr_lock_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_req,
    input  logic       c_req,
    input  logic       c_lock,
    output logic [1:0] gnt,
    output logic       lock_act
);
    import keccak_mem_pkg::*;

    logic last_core_q, last_core_d;
    logic lock_act_q, lock_act_d;
    logic [1:0] gnt_d;

    always_comb begin
        gnt_d = 2'b00;
        if (lock_act_q) begin
            gnt_d[GNT_CORE] = c_req;
        end else if (h_req && c_req) begin
            // Fairness: whoever was not granted last time wins the tie.
            if (last_core_q) gnt_d[GNT_HOST] = 1'b1;
            else             gnt_d[GNT_CORE] = 1'b1;
        end else begin
            gnt_d[GNT_CORE] = c_req;
            gnt_d[GNT_HOST] = h_req;
        end

        last_core_d = last_core_q;
        if (|gnt_d) last_core_d = gnt_d[GNT_CORE];

        // Dropping c_lock releases immediately; raising it needs a core grant.
        lock_act_d = c_lock && (lock_act_q || gnt_d[GNT_CORE]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_core_q <= 1'b0;
            lock_act_q  <= 1'b0;
        end else begin
            last_core_q <= last_core_d;
            lock_act_q  <= lock_act_d;
        end
    end

    assign gnt      = gnt_d;
    assign lock_act = lock_act_q;

endmodule

// File: rtl/mem_arbiter.sv
// Host/core arbiter in front of the single-port 64x64 lane memory.
// At most one memory op per cycle; grant is combinational with the request;
// read data returns one cycle after the read grant to the reader.
// Handshake: an op is accepted in a cycle where req && gnt; the requester
// holds req/we/addr/wdata stable until it sees gnt.
// Ports:
//   clk, rst                           : clock, asynchronous active-high reset
//   h_req/h_we/h_addr/h_wdata          : host op request
//   h_gnt, h_rvalid, h_rdata           : host grant and read return
//   c_req/c_we/c_addr/c_wdata, c_lock  : core op request and lock
//   c_gnt, c_rvalid, c_rdata           : core grant and read return
//   mem_enR/mem_enW/mem_addr/mem_wdata : memory command
//   mem_rdata                          : memory registered read data
// Optional build macro MEM_ARB_STALL_CNT_EN adds stall_clr (in) and
// h_stall_cnt[15:0] (out), a saturating count of host-stalled cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH = keccak_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = keccak_mem_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MEM_ARB_STALL_CNT_EN
    input  logic                  stall_clr,
    output logic [15:0]           h_stall_cnt,
`endif
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic                  c_lock,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  mem_enR,
    output logic                  mem_enW,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    import keccak_mem_pkg::*;

    logic [1:0] gnt;
    logic       lock_act;
    logic       h_req_v, c_req_v;
    rd_tag_t    rd_tag_q, rd_tag_d;

    // Requests are masked during reset so every output reads 0 while rst=1.
    assign h_req_v = h_req && !rst;
    assign c_req_v = c_req && !rst;

    rr_lock_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .h_req    (h_req_v),
        .c_req    (c_req_v),
        .c_lock   (c_lock),
        .gnt      (gnt),
        .lock_act (lock_act)
    );

    assign h_gnt = gnt[GNT_HOST];
    assign c_gnt = gnt[GNT_CORE];

    always_comb begin
        mem_enR   = 1'b0;
        mem_enW   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (h_gnt) begin
            mem_enW   = (h_we == OP_WR);
            mem_enR   = (h_we == OP_RD);
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (c_gnt) begin
            mem_enW   = (c_we == OP_WR);
            mem_enR   = (c_we == OP_RD);
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end
    end

    // Read tag is reloaded every cycle, so back-to-back reads need no stall.
    always_comb begin
        rd_tag_d.pend = mem_enR;
        rd_tag_d.core = c_gnt && (c_we == OP_RD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_tag_q <= '0;
        else     rd_tag_q <= rd_tag_d;
    end

    assign h_rvalid = rd_tag_q.pend && !rd_tag_q.core;
    assign c_rvalid = rd_tag_q.pend &&  rd_tag_q.core;
    assign h_rdata  = rst ? '0 : mem_rdata;
    assign c_rdata  = rst ? '0 : mem_rdata;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] h_stall_cnt_q, h_stall_cnt_d;

    always_comb begin
        h_stall_cnt_d = h_stall_cnt_q;
        if (stall_clr)
            h_stall_cnt_d = '0;
        else if (h_req_v && !h_gnt && (h_stall_cnt_q != 16'hFFFF))
            h_stall_cnt_d = h_stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) h_stall_cnt_q <= '0;
        else     h_stall_cnt_q <= h_stall_cnt_d;
    end

    assign h_stall_cnt = h_stall_cnt_q;
`endif

    // Lock state is consumed inside the picker; kept visible for debug binds.
    logic unused_lock;
    assign unused_lock = lock_act;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural lane memory and a
// read-return scoreboard.
module tb_mem_arbiter;
    import keccak_mem_pkg::*;

    localparam int AW = 6;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          h_req, h_we, c_req, c_we, c_lock;
    logic [AW-1:0] h_addr, c_addr;
    logic [DW-1:0] h_wdata, c_wdata;
    logic          h_gnt, h_rvalid, c_gnt, c_rvalid;
    logic [DW-1:0] h_rdata, c_rdata;
    logic          mem_enR, mem_enW;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STALL_CNT_EN
    logic          stall_clr;
    logic [15:0]   h_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected read data per requester, plus "due next cycle" flags.
    logic [DW-1:0] exp_h_q[$];
    logic [DW-1:0] exp_c_q[$];
    logic          h_due, c_due;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] sys_mem [64];

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MEM_ARB_STALL_CNT_EN
        .stall_clr   (stall_clr),
        .h_stall_cnt (h_stall_cnt),
`endif
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_lock    (c_lock),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .mem_enR   (mem_enR),
        .mem_enW   (mem_enW),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Single-port memory with registered read output.
    always @(posedge clk) begin
        if (mem_enW) sys_mem[mem_addr] <= mem_wdata;
        if (mem_enR) mem_rdata <= sys_mem[mem_addr];
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".h_gnt"},     64'(h_gnt),     64'd0);
        chk({tag, ".c_gnt"},     64'(c_gnt),     64'd0);
        chk({tag, ".mem_enR"},   64'(mem_enR),   64'd0);
        chk({tag, ".mem_enW"},   64'(mem_enW),   64'd0);
        chk({tag, ".mem_addr"},  64'(mem_addr),  64'd0);
        chk({tag, ".mem_wdata"}, mem_wdata,      64'd0);
        chk({tag, ".h_rvalid"},  64'(h_rvalid),  64'd0);
        chk({tag, ".c_rvalid"},  64'(c_rvalid),  64'd0);
        chk({tag, ".h_rdata"},   h_rdata,        64'd0);
        chk({tag, ".c_rdata"},   c_rdata,        64'd0);
`ifdef MEM_ARB_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(h_stall_cnt), 64'd0);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        h_req = 1'b0; h_we = OP_RD; h_addr = '0; h_wdata = '0;
        c_req = 1'b0; c_we = OP_RD; c_addr = '0; c_wdata = '0;
        c_lock = 1'b0;
    endtask

    task automatic drive_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        h_req = req; h_we = we; h_addr = a; h_wdata = d;
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
        c_req = req; c_we = we; c_addr = a; c_wdata = d; c_lock = lk;
    endtask

    // Called at posedge+1 with inputs already driven. Checks the cycle
    // at the falling edge, updates the scoreboard, returns at posedge+1.
    task automatic cycle(input string tag, input logic eh, input logic ec);
        logic          e_enw, e_enr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, d;
        @(negedge clk);
        chk({tag, ".h_gnt"}, 64'(h_gnt), 64'(eh));
        chk({tag, ".c_gnt"}, 64'(c_gnt), 64'(ec));
        e_enw = (eh && h_we) || (ec && c_we);
        e_enr = (eh && !h_we) || (ec && !c_we);
        e_addr  = eh ? h_addr  : (ec ? c_addr  : '0);
        e_wdata = eh ? h_wdata : (ec ? c_wdata : '0);
        chk({tag, ".mem_enW"},   64'(mem_enW),  64'(e_enw));
        chk({tag, ".mem_enR"},   64'(mem_enR),  64'(e_enr));
        chk({tag, ".mem_addr"},  64'(mem_addr), 64'(e_addr));
        chk({tag, ".mem_wdata"}, mem_wdata,     e_wdata);
        chk({tag, ".h_rvalid"},  64'(h_rvalid), 64'(h_due));
        chk({tag, ".c_rvalid"},  64'(c_rvalid), 64'(c_due));
        if (h_due && exp_h_q.size() > 0) begin
            d = exp_h_q.pop_front();
            chk({tag, ".h_rdata"}, h_rdata, d);
        end
        if (c_due && exp_c_q.size() > 0) begin
            d = exp_c_q.pop_front();
            chk({tag, ".c_rdata"}, c_rdata, d);
        end
        h_due = eh && !h_we;
        c_due = ec && !c_we;
        if (h_due) exp_h_q.push_back(ref_mem[h_addr]);
        if (c_due) exp_c_q.push_back(ref_mem[c_addr]);
        if (eh && h_we) ref_mem[h_addr] = h_wdata;
        if (ec && c_we) ref_mem[c_addr] = c_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_flush();
        h_due = 1'b0; c_due = 1'b0;
        exp_h_q.delete(); exp_c_q.delete();
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        sb_flush();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            sys_mem[i] = '0;
        end
        sb_flush();
`ifdef MEM_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        // Reset with both requesters active: everything must read 0.
        rst = 1'b1;
        drive_host(1'b1, OP_WR, 6'd3, 64'h1111);
        drive_core(1'b1, OP_RD, 6'd4, 64'h2222, 1'b1);
        #3;
        chk_all_zero("rst0");
        @(posedge clk);
        #1;
        chk_all_zero("rst1");
        drive_idle();
        rst = 1'b0;

        // Host-only write then read of lane 5.
        drive_host(1'b1, OP_WR, 6'd5, 64'hDEAD_BEEF_0123_4567);
        cycle("hw", 1'b1, 1'b0);
        drive_host(1'b1, OP_RD, 6'd5, 64'h0);
        cycle("hr", 1'b1, 1'b0);
        drive_idle();
        cycle("hret", 1'b0, 1'b0);

        // Fill lanes 1 and 2, then contend from a fresh reset.
        drive_host(1'b1, OP_WR, 6'd1, {$urandom, $urandom});
        cycle("pf1", 1'b1, 1'b0);
        drive_host(1'b1, OP_WR, 6'd2, {$urandom, $urandom});
        cycle("pf2", 1'b1, 1'b0);
        do_reset();
        drive_host(1'b1, OP_RD, 6'd1, 64'h0);
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b0);
        cycle("ct0", 1'b0, 1'b1);
        cycle("ct1", 1'b1, 1'b0);
        cycle("ct2", 1'b0, 1'b1);
        cycle("ct3", 1'b1, 1'b0);
        drive_idle();
        cycle("ctd", 1'b0, 1'b0);

        // Lock: core wins with c_lock, host starves for 10 cycles.
        drive_host(1'b1, OP_RD, 6'd1, 64'h0);
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b1);
        cycle("lk0", 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive_core(1'b1, (i % 2 == 0) ? OP_WR : OP_RD, 6'(20 + i / 2),
                       {$urandom, $urandom}, 1'b1);
            cycle($sformatf("lk%0d", i + 1), 1'b0, 1'b1);
        end
        // Lock still in force the cycle c_lock drops; host gets the next one.
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b0);
        cycle("ul0", 1'b0, 1'b1);
        cycle("ul1", 1'b1, 1'b0);

        // c_lock rises while the host is being granted.
        drive_host(1'b0, OP_RD, 6'd1, 64'h0);
        cycle("se0", 1'b0, 1'b1);
        drive_host(1'b1, OP_RD, 6'd1, 64'h0);
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b1);
        cycle("se1", 1'b1, 1'b0);
        cycle("se2", 1'b0, 1'b1);
        cycle("se3", 1'b0, 1'b1);
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b0);
        cycle("se4", 1'b0, 1'b1);
        drive_idle();
        cycle("sed", 1'b0, 1'b0);

        // Reset in the cycle after a core read grant.
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b0);
        cycle("rr0", 1'b0, 1'b1);
        drive_host(1'b1, OP_RD, 6'd1, 64'h0);
        rst = 1'b1;
        sb_flush();
        @(negedge clk);
        chk_all_zero("rmid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("rp0", 1'b0, 1'b1);
        cycle("rp1", 1'b1, 1'b0);
        drive_idle();
        cycle("rpd", 1'b0, 1'b0);

`ifdef MEM_ARB_STALL_CNT_EN
        // Host stalled behind a core lock for 7 cycles, then cleared.
        do_reset();
        chk("st.init", 64'(h_stall_cnt), 64'd0);
        drive_host(1'b1, OP_RD, 6'd1, 64'h0);
        drive_core(1'b1, OP_RD, 6'd2, 64'h0, 1'b1);
        for (int i = 0; i < 7; i++) cycle($sformatf("st%0d", i), 1'b0, 1'b1);
        chk("st.cnt7", 64'(h_stall_cnt), 64'd7);
        stall_clr = 1'b1;
        cycle("stclr", 1'b0, 1'b1);
        chk("st.clr", 64'(h_stall_cnt), 64'd0);
        stall_clr = 1'b0;
        cycle("st8", 1'b0, 1'b1);
        chk("st.cnt1", 64'(h_stall_cnt), 64'd1);
        drive_idle();
        cycle("std", 1'b0, 1'b0);
`endif

        chk("sb.h_empty", 64'(exp_h_q.size()), 64'd0);
        chk("sb.c_empty", 64'(exp_c_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
